// File: rtl/decoder_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// decoder_unit
//
// Decodes a 16-bit instruction packet into a registered control word.
// Packet layout:
//   [15] valid, [14:12] op_code, [11:10] comp_type, [9:8] reserved,
//   [7:4] addr, [3:1] reserved, [0] even-parity bit.
// A packet is treated as a new instruction only when its valid bit is set and
// it differs from the packet seen on the previous cycle. Holding a packet
// steady therefore decodes it once.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   instruction_packet  packet sampled on every rising edge
//   decoded_control     {valid, op_code[2:0], comp_type[1:0], addr[3:0]};
//                       holds until the next new instruction, error or reset
//   decode_valid        one-cycle pulse per accepted instruction
//   error_status        one-cycle pulse per rejected instruction;
//                       bit0 = format error, bit1 = parity error
// -----------------------------------------------------------------------------
module decoder_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction_packet,
    output logic [9:0]  decoded_control,
    output logic        decode_valid,
    output logic [1:0]  error_status
);

    // Reserved bits [9:8] and [3:1]; any of them set is a format error.
    localparam logic [15:0] RESERVED_MASK = 16'h030E;

    // Packet seen on the previous cycle. Its bit 15 is the previous-valid flag,
    // so no separate register is needed for it.
    logic [15:0] prev_packet;

    logic        pkt_valid;
    logic [2:0]  op_code;
    logic [1:0]  comp_type;
    logic [3:0]  addr;
    logic        is_new;
    logic        format_err;
    logic        parity_err;

    assign pkt_valid = instruction_packet[15];
    assign op_code   = instruction_packet[14:12];
    assign comp_type = instruction_packet[11:10];
    assign addr      = instruction_packet[7:4];

    assign is_new = pkt_valid &&
                    (!prev_packet[15] || (instruction_packet != prev_packet));

    // Opcodes 100-111 are illegal, i.e. the top opcode bit must be clear.
    assign format_err = op_code[2] || ((instruction_packet & RESERVED_MASK) != 16'h0000);

    // Even parity: the XOR of all 16 bits must be zero.
    assign parity_err = ^instruction_packet;

    always_ff @(posedge clk) begin
        // NOTE: state is assigned with <= so every register samples the
        // pre-edge values, regardless of statement order in this block.
        if (rst) begin
            prev_packet     <= '0;
            decoded_control <= '0;
            decode_valid    <= 1'b0;
            error_status    <= 2'b00;
        end else begin
            prev_packet <= instruction_packet;

            // NOTE: the pulse outputs default low each cycle and are raised
            // only below, which is what makes them single-cycle.
            decode_valid <= 1'b0;
            error_status <= 2'b00;

            if (is_new) begin
                if (format_err || parity_err) begin
                    // Rejected: drop the valid bit, keep the remaining fields.
                    error_status       <= {parity_err, format_err};
                    decoded_control[9] <= 1'b0;
                end else begin
                    decoded_control <= {1'b1, op_code, comp_type, addr};
                    decode_valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decoder_unit.sv
`timescale 1ns/1ps
module tb_decoder_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction_packet = 16'h0000;
    logic [9:0]  decoded_control;
    logic        decode_valid;
    logic [1:0]  error_status;

    decoder_unit dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_packet (instruction_packet),
        .decoded_control    (decoded_control),
        .decode_valid       (decode_valid),
        .error_status       (error_status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model: works on the packet as an integer and
    // derives fields and errors arithmetically.
    // ------------------------------------------------------------------
    logic [9:0]  m_ctrl = '0;
    logic        m_dv   = 1'b0;
    logic [1:0]  m_err  = 2'b00;
    int          m_prev = 0;

    always @(posedge clk) begin
        int p, op, comp, addr, ones;
        bit bad_fmt, bad_par;
        if (rst) begin
            m_ctrl = '0;
            m_dv   = 1'b0;
            m_err  = 2'b00;
            m_prev = 0;
        end else begin
            p    = int'(instruction_packet);
            m_dv  = 1'b0;
            m_err = 2'b00;
            if (p >= 32768 && p != m_prev) begin
                op      = (p / 4096) % 8;
                comp    = (p / 1024) % 4;
                addr    = (p / 16) % 16;
                ones    = $countones(instruction_packet);
                bad_fmt = (op > 3) || ((p / 256) % 4 != 0) || ((p / 2) % 8 != 0);
                bad_par = (ones % 2) == 1;
                if (bad_fmt || bad_par) begin
                    m_err  = 2'(int'(bad_par) * 2 + int'(bad_fmt));
                    m_ctrl = m_ctrl % 10'd512;
                end else begin
                    m_ctrl = 10'(512 + op * 64 + comp * 16 + addr);
                    m_dv   = 1'b1;
                end
            end
            m_prev = p;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ctrl", 16'(decoded_control), 16'(m_ctrl));
            check("model_dv",   16'(decode_valid),    16'(m_dv));
            check("model_err",  16'(error_status),    16'(m_err));
        end
    end

    // Present a packet, let one rising edge sample it, settle past the edge.
    task automatic apply(input logic [15:0] p, input logic r);
        instruction_packet = p;
        rst                = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] ctrl,
                              input logic dv, input logic [1:0] err);
        check({tag, "_ctrl"}, 16'(decoded_control), 16'(ctrl));
        check({tag, "_dv"},   16'(decode_valid),    16'(dv));
        check({tag, "_err"},  16'(error_status),    16'(err));
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] last_p;
        logic        r;

        // Reset state
        apply(16'h0000, 1'b1);
        apply(16'h0000, 1'b1);
        cmp_en = 1'b1;
        expect_out("reset", 10'h000, 1'b0, 2'b00);

        // Load held for three cycles: one pulse, control word held
        apply(16'h9050, 1'b0);
        expect_out("load1", 10'h245, 1'b1, 2'b00);
        apply(16'h9050, 1'b0);
        expect_out("load2", 10'h245, 1'b0, 2'b00);
        apply(16'h9050, 1'b0);
        expect_out("load3", 10'h245, 1'b0, 2'b00);

        // Packet with valid bit clear changes nothing
        apply(16'h1050, 1'b0);
        expect_out("invalid", 10'h245, 1'b0, 2'b00);

        // Back-to-back LOAD then COMP/MUL
        apply(16'h0000, 1'b0);
        apply(16'h9050, 1'b0);
        expect_out("b2b_load", 10'h245, 1'b1, 2'b00);
        apply(16'hB400, 1'b0);
        expect_out("b2b_comp", 10'h2D0, 1'b1, 2'b00);

        // Errors, each preceded by an idle packet, each lasting one cycle
        apply(16'h0000, 1'b0);
        apply(16'h9051, 1'b0);
        expect_out("parity_err", 10'h0D0, 1'b0, 2'b10);
        apply(16'h0000, 1'b0);
        expect_out("parity_clr", 10'h0D0, 1'b0, 2'b00);
        apply(16'hF000, 1'b0);
        expect_out("format_err", 10'h0D0, 1'b0, 2'b01);
        apply(16'h0000, 1'b0);
        expect_out("format_clr", 10'h0D0, 1'b0, 2'b00);
        apply(16'h9052, 1'b0);
        expect_out("both_err", 10'h0D0, 1'b0, 2'b11);
        apply(16'h0000, 1'b0);
        expect_out("both_clr", 10'h0D0, 1'b0, 2'b00);

        // Reset with a valid packet held through it
        apply(16'h9050, 1'b0);
        expect_out("pre_rst", 10'h245, 1'b1, 2'b00);
        apply(16'h9050, 1'b1);
        expect_out("in_rst1", 10'h000, 1'b0, 2'b00);
        apply(16'h9050, 1'b1);
        expect_out("in_rst2", 10'h000, 1'b0, 2'b00);
        apply(16'h9050, 1'b0);
        expect_out("post_rst", 10'h245, 1'b1, 2'b00);

        // Reset in the same cycle a new packet arrives cancels it
        apply(16'hB400, 1'b1);
        expect_out("cancel_rst", 10'h000, 1'b0, 2'b00);
        apply(16'h0000, 1'b0);
        expect_out("cancel_after", 10'h000, 1'b0, 2'b00);

        // Randomised traffic, biased towards repeats and well-formed packets
        last_p = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                p = last_p;
            end else begin
                p = 16'($urandom);
                if ($urandom_range(0, 3) != 0) p = p & ~16'h030E;
                if ($urandom_range(0, 3) != 0) p[14] = 1'b0;
                if ($urandom_range(0, 3) != 0) p[15] = 1'b1;
                if ($urandom_range(0, 3) != 0) p[0] = p[0] ^ (^p);
            end
            r = ($urandom_range(0, 49) == 0);
            apply(p, r);
            last_p = p;
        end

        apply(16'h0000, 1'b0);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
